mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer owning the HI/LO registers of the 5-stage core.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs one iteration per cycle.
- Commits the result to HI/LO when the operation finishes.
- Drives a stall request that the pipeline interface controller ORs into its bubble/freeze condition, so a HI/LO-dependent instruction in ID waits until the result is ready.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_BIT, 6, iteration counter width; must satisfy 2^CNT_BIT > WIDTH.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ex_start  in  1  EX holds a valid (non-bubble) mul/div instruction.
- ex_op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- ex_src_a  in  WIDTH  rs operand (multiplicand/dividend).
- ex_src_b  in  WIDTH  rt operand (multiplier/divisor).
- ex_hilo_we  in  2  {MTHI, MTLO} write enables from EX.
- ex_hilo_wdat  in  WIDTH  MTHI/MTLO data.
- id_hilo_use  in  1  ID instruction is mul/div/MFHI/MFLO/MTHI/MTLO.
- stall  out  1  combinational; freeze PC/IFID and bubble IDEX.
- busy  out  1  operation in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- done  out  1  one-cycle pulse; HI/LO were just committed.
- div_zero  out  1  one-cycle pulse with done for a divide by 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, hi=lo=0, busy=0, done=0, div_zero=0, all internal operand registers 0. Reset mid-operation aborts with no partial commit.
- States: IDLE, RUN, FIX. busy = (state != IDLE).
- IDLE, ex_start=1 at edge E0:
  - Latch operand magnitudes (signed ops: abs value of each operand).
  - Latch the negate-result and negate-remainder flags and the op kind.
  - Set counter to WIDTH-1; go to RUN.
- RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle, W=WIDTH cycles (edges E1..E_W). Counter decrements; at counter 0 go to FIX.
- FIX: sign correction, then write HI/LO at edge E_{W+1}; go to IDLE.
  - done and div_zero are registered pulses, high during the cycle after E_{W+1}.
  - Total: busy high W+1 cycles; result visible W+1 cycles after the accept edge.
- Multiply: 2W-bit product, HI = upper W bits, LO = lower W bits. Signed: negate the full 2W product iff the operand signs differ.
- Divide: LO = quotient, HI = remainder.
  - Signed: quotient negated iff signs differ; remainder takes the dividend's sign.
  - INT_MIN / -1: LO=INT_MIN, HI=0.
  - Divisor 0 (any signedness): LO=all ones, HI=ex_src_a unchanged, div_zero pulses.
- MTHI/MTLO: in IDLE with ex_start=0, ex_hilo_we[1] writes hi and ex_hilo_we[0] writes lo at the clock edge.
- Writes from EX are ignored while busy. The stall rule guarantees this case never occurs.
- ex_start in the same cycle as a nonzero ex_hilo_we: ex_start wins.
- ex_start while busy: ignored; no restart.
- stall = id_hilo_use && (ex_start || state==RUN).
  - In FIX, stall is low: the ID instruction enters EX on the same edge that HI/LO commit, so it reads the new value.
  - stall does not depend on any registered stall state.
- hi/lo are registers and hold their value between commits.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high exactly 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001; done pulses once.
2. MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
3. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007, with div_zero and done pulsing in the same cycle.
4. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
5. id_hilo_use=1 held from the ex_start cycle -> stall high for 33 consecutive cycles (start cycle + 32 RUN), low in FIX. MFHI entering EX on the next edge sees the new HI.
6. rst_n low at RUN iteration 10 -> busy, stall, hi, lo, done all 0 immediately, with no later commit. After reset, MTLO 0x1234 -> lo=0x1234, hi=0.

Source files
------------

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer owning HI/LO; one shift-add or shift-subtract step per cycle.
// Latency: WIDTH+1 cycles from accept edge to HI/LO commit (done pulses the cycle after commit).
// Backpressure: stall asks the pipeline to hold a HI/LO user in ID while a start or RUN is in progress.
module mdu_seq #(
    parameter int WIDTH   = 32,
    parameter int CNT_BIT = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_start,
    input  logic [1:0]       ex_op,
    input  logic [WIDTH-1:0] ex_src_a,
    input  logic [WIDTH-1:0] ex_src_b,
    input  logic [1:0]       ex_hilo_we,
    input  logic [WIDTH-1:0] ex_hilo_wdat,
    input  logic             id_hilo_use,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CNT_BIT-1:0] cnt;
    logic [WIDTH:0]     p_hi;      // partial product high half / division remainder (extra carry bit)
    logic [WIDTH-1:0]   p_lo;      // multiplier being consumed / dividend shifting into quotient
    logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   raw_a;     // original dividend, returned in HI on divide by zero
    logic               neg_res;
    logic               neg_rem;
    logic               is_div;
    logic               div0;

    // Operand decode at accept: ex_op[1] selects divide, ex_op[0] selects signed.
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    // Datapath step and final sign correction.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op_signed = ex_op[0];
    assign a_mag     = (op_signed && ex_src_a[WIDTH-1]) ? -ex_src_a : ex_src_a;
    assign b_mag     = (op_signed && ex_src_b[WIDTH-1]) ? -ex_src_b : ex_src_b;

    assign mul_sum   = p_hi + (p_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign div_shift = {p_hi[WIDTH-1:0], p_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};

    assign prod      = {p_hi[WIDTH-1:0], p_lo};
    assign prod_fix  = neg_res ? -prod : prod;
    assign quo_fix   = neg_res ? -p_lo : p_lo;
    assign rem_fix   = neg_rem ? -p_hi[WIDTH-1:0] : p_hi[WIDTH-1:0];

    assign busy  = (state != IDLE);
    // FIX is deliberately excluded: the waiting instruction enters EX on the commit edge.
    assign stall = id_hilo_use && (ex_start || state == RUN);

    // Sequencer FSM, datapath registers, HI/LO and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            opb      <= '0;
            raw_a    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
            div0     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_start) begin
                        p_hi    <= '0;
                        p_lo    <= a_mag;
                        opb     <= b_mag;
                        raw_a   <= ex_src_a;
                        is_div  <= ex_op[1];
                        div0    <= (ex_src_b == '0);
                        neg_res <= op_signed && (ex_src_a[WIDTH-1] ^ ex_src_b[WIDTH-1]);
                        neg_rem <= op_signed && ex_src_a[WIDTH-1];
                        cnt     <= CNT_BIT'(WIDTH-1);
                        state   <= RUN;
                    end else begin
                        if (ex_hilo_we[1]) hi <= ex_hilo_wdat;
                        if (ex_hilo_we[0]) lo <= ex_hilo_wdat;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        // Restoring step: keep the difference only if it did not borrow.
                        p_hi <= div_diff[WIDTH] ? div_shift : div_diff;
                        p_lo <= {p_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        {p_hi, p_lo} <= {mul_sum, p_lo} >> 1;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div0) begin
                        hi <= raw_a;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done     <= 1'b1;
                    div_zero <= is_div && div0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: multiply/divide results, timing of busy/stall/done, MTHI/MTLO, reset abort.
// Inputs driven on the falling edge, outputs sampled #1 after it.
// Pass/fail summary printed at the end.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_start;
    logic [1:0]  ex_op;
    logic [31:0] ex_src_a;
    logic [31:0] ex_src_b;
    logic [1:0]  ex_hilo_we;
    logic [31:0] ex_hilo_wdat;
    logic        id_hilo_use;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    mdu_seq #(.WIDTH(32), .CNT_BIT(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_start     (ex_start),
        .ex_op        (ex_op),
        .ex_src_a     (ex_src_a),
        .ex_src_b     (ex_src_b),
        .ex_hilo_we   (ex_hilo_we),
        .ex_hilo_wdat (ex_hilo_wdat),
        .id_hilo_use  (id_hilo_use),
        .stall        (stall),
        .busy         (busy),
        .hi           (hi),
        .lo           (lo),
        .done         (done),
        .div_zero     (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op and run it to completion; returns busy-cycle and stall-cycle counts,
    // plus done/div_zero as seen in the first cycle after busy falls.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int bcnt, output int scnt, output logic d, output logic dz);
        bcnt = 0;
        scnt = 0;
        @(negedge clk);
        ex_start = 1'b1;
        ex_op    = op;
        ex_src_a = a;
        ex_src_b = b;
        #1;
        if (stall) scnt++;
        @(negedge clk);
        ex_start = 1'b0;
        #1;
        while (busy && bcnt < 100) begin
            bcnt++;
            if (stall) scnt++;
            @(negedge clk);
            #1;
        end
        d  = done;
        dz = div_zero;
    endtask

    int   bc, sc, dcnt;
    logic d, dz;

    initial begin
        rst_n        = 1'b0;
        ex_start     = 1'b0;
        ex_op        = 2'b00;
        ex_src_a     = '0;
        ex_src_b     = '0;
        ex_hilo_we   = 2'b00;
        ex_hilo_wdat = '0;
        id_hilo_use  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        rst_n = 1'b1;

        // MULTU max x max
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, sc, d, dz);
        chk("multu_busy_cyc", bc, 33);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        chk("multu_done", {31'b0, d}, 32'h1);
        @(negedge clk); #1;
        chk("multu_done_once", {31'b0, done}, 32'h0);

        // MULT -3 x 7
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, bc, sc, d, dz);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFEB);

        // MULT INT_MIN x INT_MIN
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, bc, sc, d, dz);
        chk("mult_min_hi", hi, 32'h4000_0000);
        chk("mult_min_lo", lo, 32'h0000_0000);

        // DIV -7 / 2
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, bc, sc, d, dz);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        chk("div_neg_dz", {31'b0, dz}, 32'h0);

        // DIVU 7 / 0
        run_op(2'b10, 32'd7, 32'd0, bc, sc, d, dz);
        chk("divz_lo", lo, 32'hFFFF_FFFF);
        chk("divz_hi", hi, 32'h0000_0007);
        chk("divz_dz", {31'b0, dz}, 32'h1);
        chk("divz_done", {31'b0, d}, 32'h1);

        // DIV -5 / 0: HI keeps the raw dividend
        run_op(2'b11, 32'hFFFF_FFFB, 32'd0, bc, sc, d, dz);
        chk("divz_s_hi", hi, 32'hFFFF_FFFB);
        chk("divz_s_lo", lo, 32'hFFFF_FFFF);

        // DIV INT_MIN / -1
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, bc, sc, d, dz);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0000_0000);
        chk("div_ovf_dz", {31'b0, dz}, 32'h0);

        // DIVU 100 / 7 with ID waiting on HI/LO: stall covers start cycle plus RUN
        id_hilo_use = 1'b1;
        run_op(2'b10, 32'd100, 32'd7, bc, sc, d, dz);
        chk("stall_cyc", sc, 33);
        chk("stall_busy_cyc", bc, 33);
        chk("stall_mfhi", hi, 32'd2);
        chk("stall_mflo", lo, 32'd14);

        // MTHI writes hi only
        @(negedge clk);
        ex_hilo_we = 2'b10; ex_hilo_wdat = 32'hCAFE_0001;
        @(negedge clk);
        ex_hilo_we = 2'b00;
        #1;
        chk("mthi_hi", hi, 32'hCAFE_0001);
        chk("mthi_lo", lo, 32'd14);

        // Reset during RUN iteration 10 aborts with no commit
        @(negedge clk);
        ex_start = 1'b1; ex_op = 2'b00; ex_src_a = 32'd3; ex_src_b = 32'd5;
        @(negedge clk);
        ex_start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_stall", {31'b0, stall}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        id_hilo_use = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done || busy) dcnt++;
        end
        chk("abort_no_commit", dcnt, 0);
        chk("abort_lo_after", lo, 32'h0);

        // MTLO after reset
        @(negedge clk);
        ex_hilo_we = 2'b01; ex_hilo_wdat = 32'h0000_1234;
        @(negedge clk);
        ex_hilo_we = 2'b00;
        #1;
        chk("mtlo_lo", lo, 32'h0000_1234);
        chk("mtlo_hi", hi, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
